// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for a shared 16-bit data / 24-bit address bus with four
// requesters (bit 0 is the CPU, bits 1..3 are expansion ports). A grant lasts
// until the owner drops its request or until HOLD_MAX cycles have elapsed.
// Every tenure is followed by exactly one turnaround cycle with no grant, so
// two bus drivers never overlap.
//
// Parameters:
//   HOLD_MAX  maximum tenure in cycles of gnt high (legal range 2..256)
//
// Ports:
//   clk      in   system clock, all state updates on its rising edge
//   r        in   synchronous active-high reset
//   req      in   [3:0] per-requester bus request
//   gnt      out  [3:0] registered grant, zero or one-hot
//   owner    out  [1:0] index of the current grantee, valid while busy=1
//   busy     out  high while some requester holds the bus (OR of gnt)
//   timeout  out  one-cycle pulse in the turnaround after a forced tenure end
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       r,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // The hold counter only ever needs to reach HOLD_MAX-1.
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    ptr;
    logic [1:0]    ptr_next;
    logic [1:0]    owner_next;
    logic [3:0]    gnt_next;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_next;
    logic          timeout_next;

    logic [1:0]    win;
    logic          any_req;
    logic          owner_req;
    logic          hold_expired;

    assign any_req      = |req;
    assign owner_req    = req[owner];
    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign busy         = |gnt;

    // Round-robin search: start at ptr and walk upward mod 4, the first
    // asserted request wins. Since ptr moves to just past each grantee, the
    // previous owner is always the last candidate considered.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // State register together with the registered outputs and bookkeeping.
    // Reset clears everything on the same edge, so a mid-tenure reset drops
    // gnt immediately without passing through TURN.
    always_ff @(posedge clk) begin
        if (r) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            owner    <= owner_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
            timeout  <= timeout_next;
        end
    end

    // Next-state logic. GRANT always leaves through TURN, whether the owner
    // released the bus or its tenure was cut short.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   if (!owner_req || hold_expired) state_next = TURN;
            TURN:    state_next = any_req ? GRANT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: computes the values registered at the next edge.
    // Arbitration happens only in IDLE and TURN; during GRANT the other
    // request lines are ignored and only the owner's line and the hold
    // counter matter.
    always_comb begin
        gnt_next     = gnt;
        owner_next   = owner;
        ptr_next     = ptr;
        hold_next    = hold_cnt;
        timeout_next = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (any_req) begin
                    gnt_next   = 4'b0001 << win;
                    owner_next = win;
                    ptr_next   = win + 2'd1;
                    hold_next  = '0;
                end else begin
                    gnt_next = 4'b0000;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_next = 4'b0000;
                end else if (hold_expired) begin
                    gnt_next     = 4'b0000;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_cnt + CW'(1);
                end
            end
            default: begin
                gnt_next = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. Instance A uses HOLD_MAX=16 and runs a
// vector table (reset priority, rotation, one-cycle tenure, ignored requests
// during a tenure, mid-tenure reset) followed by a hand-written timeout
// sequence. Instance B uses HOLD_MAX=4 and checks alternation of two
// permanent requesters under forced tenure ends.
//
// Each vector holds the inputs driven for one cycle and the outputs expected
// just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk;
    logic       r_a;
    logic [3:0] req_a;
    logic [3:0] gnt_a;
    logic [1:0] owner_a;
    logic       busy_a;
    logic       timeout_a;

    logic       r_b;
    logic [3:0] req_b;
    logic [3:0] gnt_b;
    logic [1:0] owner_b;
    logic       busy_b;
    logic       timeout_b;

    int checks;
    int failures;

    typedef struct packed {
        logic       r;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       owner_valid;
    } vec_t;

    vec_t vecs[$];

    bus_arbiter #(.HOLD_MAX(16)) dut_a (
        .clk     (clk),
        .r       (r_a),
        .req     (req_a),
        .gnt     (gnt_a),
        .owner   (owner_a),
        .busy    (busy_a),
        .timeout (timeout_a)
    );

    bus_arbiter #(.HOLD_MAX(4)) dut_b (
        .clk     (clk),
        .r       (r_b),
        .req     (req_b),
        .gnt     (gnt_b),
        .owner   (owner_b),
        .busy    (busy_b),
        .timeout (timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {gnt, owner, busy, timeout}.
    function automatic logic [7:0] packA();
        return {gnt_a, owner_a, busy_a, timeout_a};
    endfunction

    function automatic logic [7:0] packB();
        return {gnt_b, owner_b, busy_b, timeout_b};
    endfunction

    task automatic addVec(input logic rr, input logic [3:0] rq, input logic [3:0] g,
                          input logic [1:0] o, input logic b, input logic ov);
        vec_t v;
        v.r           = rr;
        v.req         = rq;
        v.gnt         = g;
        v.owner       = o;
        v.busy        = b;
        v.owner_valid = ov;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the chosen instance, then move to just
    // after the next rising edge where outputs are stable.
    task automatic applyStimulus(input logic sel_b, input logic rr, input logic [3:0] rq);
        if (sel_b) begin
            r_b   = rr;
            req_b = rq;
        end else begin
            r_a   = rr;
            req_a = rq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp, input logic [7:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b mask=%b", name, act, exp, mask);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        r_a   = 1'b1;
        req_a = 4'b0000;
        r_b   = 1'b1;
        req_b = 4'b0000;
        @(posedge clk);
        #1;

        // Reset state, then reset priority with all four requesting.
        addVec(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
        // Rotation: two-cycle tenures, owner drops req for one cycle.
        addVec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
        addVec(1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
        addVec(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
        addVec(1'b0, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
        addVec(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
        addVec(1'b0, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Single-cycle pulse on req[3] in IDLE: one-cycle tenure, TURN, IDLE.
        addVec(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // CPU short tenure moves ptr to 1, then requester 2 gets a tenure
        // during which req[1] rises without effect.
        addVec(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        // Reset in cycle 5 of the tenure, then re-grant once r falls.
        addVec(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].r, vecs[i].req);
            checkOutput($sformatf("vec%0d", i), packA(),
                        {vecs[i].gnt, vecs[i].owner, vecs[i].busy, 1'b0},
                        vecs[i].owner_valid ? 8'hFF : 8'hF3);
        end

        // Sole requester 1 held: 16 cycles of grant, one timeout TURN, re-grant.
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("to_first", packA(), {4'b0010, 2'd1, 1'b1, 1'b0}, 8'hFF);
        n = 1;
        while (gnt_a == 4'b0010 && n < 40) begin
            applyStimulus(1'b0, 1'b0, 4'b0010);
            if (gnt_a == 4'b0010) n++;
        end
        checkOutput("to_len", 8'(n), 8'd16, 8'hFF);
        checkOutput("to_turn", packA(), {4'b0000, 2'd0, 1'b0, 1'b1}, 8'hF3);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("to_regrant", packA(), {4'b0010, 2'd1, 1'b1, 1'b0}, 8'hFF);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("to_hold", packA(), {4'b0010, 2'd1, 1'b1, 1'b0}, 8'hFF);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("to_release", packA(), {4'b0000, 2'd0, 1'b0, 1'b0}, 8'hF3);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("to_idle", packA(), {4'b0000, 2'd0, 1'b0, 1'b0}, 8'hF3);

        // HOLD_MAX=4 with req 0011 held: owners 0,1,0,1 for four cycles each,
        // each separated by a TURN cycle carrying the timeout pulse.
        for (int c = 0; c < 20; c++) begin
            int t;
            int p;
            logic [7:0] exp;
            logic [7:0] mask;
            t = c / 5;
            p = c % 5;
            if (p < 4) begin
                exp  = {((t % 2) != 0) ? 4'b0010 : 4'b0001, 2'(t % 2), 1'b1, 1'b0};
                mask = 8'hFF;
            end else begin
                exp  = {4'b0000, 2'd0, 1'b1 ^ 1'b1, 1'b1};
                mask = 8'hF3;
            end
            applyStimulus(1'b1, 1'b0, 4'b0011);
            checkOutput($sformatf("fair%0d", c), packB(), exp, mask);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
